lsu_mem_master: RTL and testbench

//  Load/store initiator for the M stage. Turns mem_readM/mem_writeM into valid/ready requests
//  to a variable-latency data memory. Generates byte enables, waits for read data, and

---
 rtl/lsu_mem_master.sv | 190 +++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// M-stage load/store initiator: valid/ready requests to a variable-latency data memory.
// Optional request/response timeout abort when LSU_TIMEOUT_EN is defined.
module lsu_mem_master #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_readM,
  input  logic        mem_writeM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] alu_resultM,
  input  logic [31:0] write_dataM,
  output logic        stallM,
  output logic [31:0] load_dataM,
  output logic        load_validM,
  output logic        lsu_err,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, load_data_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic        access, illegal, capture, rsp_take;
  logic        timeout, aborted;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, ext_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign access = mem_readM | mem_writeM;

  always_comb begin
    illegal = 1'b0;
    case (funct3M)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = alu_resultM[0];
      3'b010:         illegal = |alu_resultM[1:0];
      default:        illegal = 1'b1;
    endcase
    if (mem_writeM && funct3M[2]) illegal = 1'b1;
    if (mem_readM && mem_writeM)  illegal = 1'b1;
  end

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << addr_q[1:0];
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    byte_sel = rsp_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    case (f3_q)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext_data = {24'h0, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext_data = {16'h0, half_sel};
      default: ext_data = rsp_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        aborted_q;

  assign timeout = ((state_q == REQ) || (state_q == WAIT)) && (to_cnt_q == TIMEOUT_CYC - 32'd1);
  assign aborted = aborted_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      if (capture)
        to_cnt_q <= '0;
      else if ((state_q == REQ) || (state_q == WAIT))
        to_cnt_q <= to_cnt_q + 32'd1;
      if (capture)
        aborted_q <= 1'b0;
      else if (timeout)
        aborted_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign aborted = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    stallM      = 1'b0;
    req_valid   = 1'b0;
    lsu_err     = 1'b0;
    load_validM = 1'b0;
    capture     = 1'b0;
    rsp_take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (illegal) begin
            lsu_err = 1'b1;
          end else begin
            stallM  = 1'b1;
            capture = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stallM = 1'b1;
        if (timeout) begin
          lsu_err = 1'b1;
          state_d = DONE;
        end else begin
          req_valid = 1'b1;
          if (req_ready) state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        stallM = 1'b1;
        if (timeout) begin
          lsu_err = 1'b1;
          state_d = DONE;
        end else if (rsp_valid) begin
          rsp_take = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        load_validM = ~we_q & ~aborted;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      we_q        <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q  <= alu_resultM;
        wdata_q <= write_dataM;
        f3_q    <= funct3M;
        we_q    <= mem_writeM;
      end
      if (rsp_take)
        load_data_q <= ext_data;
      else if (timeout)
        load_data_q <= '0;
    end
  end

  // Request fields are forced to zero outside REQ so idle/reset outputs read as 0.
  assign req_we     = (state_q == REQ) & we_q;
  assign req_addr   = (state_q == REQ) ? {addr_q[31:2], 2'b00} : '0;
  assign req_wdata  = (state_q == REQ) ? lane_wdata : '0;
  assign req_be     = (state_q == REQ) ? lane_be : '0;
  assign load_dataM = load_data_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: vector table plus hand sequences for reset and back-to-back.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n, mem_readM, mem_writeM, req_ready, rsp_valid;
  logic [2:0]  funct3M;
  logic [31:0] alu_resultM, write_dataM, rsp_rdata;
  logic        stallM, load_validM, lsu_err, req_valid, req_we;
  logic [31:0] load_dataM, req_addr, req_wdata;
  logic [3:0]  req_be;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_readM(mem_readM), .mem_writeM(mem_writeM),
    .funct3M(funct3M), .alu_resultM(alu_resultM), .write_dataM(write_dataM),
    .stallM(stallM), .load_dataM(load_dataM), .load_validM(load_validM), .lsu_err(lsu_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    int          rdy, rsp;
    logic [31:0] word;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_ld;
    int          e_stall, e_req, e_lv, e_err;
  } vec_t;

  vec_t v[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_readM = 1'b0; mem_writeM = 1'b0; funct3M = '0;
    alu_resultM = '0; write_dataM = '0; req_ready = 1'b0; rsp_valid = 1'b0;
  endtask

  // One access with a simple memory responder; collects what the DUT did.
  task automatic do_access(input vec_t t, output logic [3:0] be_o, output logic [31:0] addr_o,
                           output logic [31:0] wdata_o, output logic we_o, output logic first_stall,
                           output int stall_n, output int req_n, output int lv_n, output int err_n,
                           output logic [31:0] ld_o, output logic stable, output logic done);
    logic acc;
    int   since;
    be_o = '0; addr_o = '0; wdata_o = '0; we_o = 1'b0; first_stall = 1'b0;
    stall_n = 0; req_n = 0; lv_n = 0; err_n = 0; ld_o = '0; stable = 1'b1; done = 1'b0;
    acc = 1'b0; since = 0;
    @(negedge clk);
    mem_readM = t.rd; mem_writeM = t.wr; funct3M = t.f3;
    alu_resultM = t.a; write_dataM = t.wd; rsp_rdata = t.word;
    for (int c = 0; c < 80; c++) begin
      req_ready = (req_n >= t.rdy);
      rsp_valid = acc && (since == t.rsp);
      #1;
      if (c == 0) first_stall = stallM;
      else if (stallM) stall_n++;
      if (req_valid) begin
        if (req_n == 0) begin
          be_o = req_be; addr_o = req_addr; wdata_o = req_wdata; we_o = req_we;
        end else if (req_be !== be_o || req_addr !== addr_o || req_wdata !== wdata_o || req_we !== we_o) begin
          stable = 1'b0;
        end
        req_n++;
        if (req_ready) begin acc = 1'b1; since = 0; end
      end
      if (acc) since++;
      lv_n  += int'(load_validM);
      err_n += int'(lsu_err);
      if (load_validM) ld_o = load_dataM;
      if (!stallM) begin done = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    lv_n  += int'(load_validM);
    err_n += int'(lsu_err);
  endtask

  initial begin
    logic [3:0]  be_o;
    logic [31:0] addr_o, wdata_o, ld_o;
    logic        we_o, fs, stable, done;
    int          stall_n, req_n, lv_n, err_n, tcyc;
    string       tag;

    v[0]  = '{1'b0, 1'b1, 3'b010, 32'h104, 32'hA5A51234, 0, 0, 32'h0, 4'b1111, 32'h104, 32'hA5A51234, 32'h0, 1, 1, 0, 0};
    v[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF7F01, 4'b1000, 32'h100, 32'h0, 32'hFFFFFF80, 2, 1, 1, 0};
    v[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80FF7F01, 4'b1000, 32'h100, 32'h0, 32'h00000080, 2, 1, 1, 0};
    v[3]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 1, 32'h80FF7F01, 4'b1100, 32'h100, 32'h0, 32'hFFFF80FF, 2, 1, 1, 0};
    v[4]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 0, 1, 32'h80FF7F01, 4'b0011, 32'h100, 32'h0, 32'h00007F01, 2, 1, 1, 0};
    v[5]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 1, 32'h80FF7F01, 4'b1111, 32'h100, 32'h0, 32'h80FF7F01, 2, 1, 1, 0};
    v[6]  = '{1'b0, 1'b1, 3'b000, 32'h102, 32'h55, 0, 0, 32'h0, 4'b0100, 32'h100, 32'h55555555, 32'h0, 1, 1, 0, 0};
    v[7]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 0, 0, 32'h0, 4'b1100, 32'h100, 32'hBEEFBEEF, 32'h0, 1, 1, 0, 0};
    v[8]  = '{1'b1, 1'b0, 3'b010, 32'h202, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1};
    v[9]  = '{1'b1, 1'b0, 3'b001, 32'h201, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1};
    v[10] = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h77, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1};
    v[11] = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1};
    v[12] = '{1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1};
    v[13] = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 5, 3, 32'h80FF7F01, 4'b0010, 32'h100, 32'h0, 32'h0000007F, 9, 6, 1, 0};
    v[14] = '{1'b0, 1'b1, 3'b010, 32'h10C, 32'hDEADBEEF, 3, 0, 32'h0, 4'b1111, 32'h10C, 32'hDEADBEEF, 32'h0, 4, 4, 0, 0};

    clear_inputs();
    rsp_rdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'h0, stallM}, 32'h0);
    chk("rst_req_valid", {31'h0, req_valid}, 32'h0);
    chk("rst_load_valid", {31'h0, load_validM}, 32'h0);
    chk("rst_err", {31'h0, lsu_err}, 32'h0);
    chk("rst_load_data", load_dataM, 32'h0);
    chk("rst_req_be", {28'h0, req_be}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      do_access(v[i], be_o, addr_o, wdata_o, we_o, fs, stall_n, req_n, lv_n, err_n, ld_o, stable, done);
      tag = $sformatf("v%0d", i);
      chk({tag, "_done"}, {31'h0, done}, 32'h1);
      chk({tag, "_first_stall"}, {31'h0, fs}, (v[i].e_err == 0) ? 32'h1 : 32'h0);
      chk({tag, "_stall_cycles"}, stall_n, v[i].e_stall);
      chk({tag, "_req_cycles"}, req_n, v[i].e_req);
      chk({tag, "_load_valid"}, lv_n, v[i].e_lv);
      chk({tag, "_err"}, err_n, v[i].e_err);
      if (v[i].e_req > 0) begin
        chk({tag, "_be"}, {28'h0, be_o}, {28'h0, v[i].e_be});
        chk({tag, "_addr"}, addr_o, v[i].e_addr);
        chk({tag, "_we"}, {31'h0, we_o}, {31'h0, v[i].wr});
        chk({tag, "_stable"}, {31'h0, stable}, 32'h1);
        if (v[i].wr) chk({tag, "_wdata"}, wdata_o, v[i].e_wdata);
      end
      if (v[i].e_lv > 0) chk({tag, "_load_data"}, ld_o, v[i].e_ld);
    end

    // Back-to-back: store, then a load presented in the cycle right after DONE.
    @(negedge clk);
    mem_writeM = 1'b1; funct3M = 3'b010; alu_resultM = 32'h100; write_dataM = 32'h1; req_ready = 1'b1;
    rsp_rdata = 32'h80FF7F01;
    @(negedge clk); #1;
    chk("b2b_req_valid", {31'h0, req_valid}, 32'h1);
    @(negedge clk); #1;
    chk("b2b_done_stall", {31'h0, stallM}, 32'h0);
    @(negedge clk);
    mem_writeM = 1'b0; mem_readM = 1'b1; #1;
    chk("b2b_next_stall", {31'h0, stallM}, 32'h1);
    @(negedge clk); #1;
    chk("b2b_load_req", {30'h0, req_valid, req_we}, 32'h2);
    @(negedge clk);
    rsp_valid = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0; #1;
    chk("b2b_load_valid", {31'h0, load_validM}, 32'h1);
    chk("b2b_load_data", load_dataM, 32'h80FF7F01);
    @(negedge clk);
    clear_inputs();

    // Reset while waiting for read data; a late response must be ignored.
    @(negedge clk);
    mem_readM = 1'b1; funct3M = 3'b010; alu_resultM = 32'h100; req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("mid_wait_stall", {31'h0, stallM}, 32'h1);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("mid_rst_outputs", {28'h0, stallM, req_valid, load_validM, lsu_err}, 32'h0);
    chk("mid_rst_load_data", load_dataM, 32'h0);
    rsp_valid = 1'b1;
    lv_n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      rsp_valid = 1'b0;
      lv_n += int'(load_validM);
    end
    chk("late_rsp_load_valid", lv_n, 0);

`ifdef LSU_TIMEOUT_EN
    @(negedge clk);
    mem_readM = 1'b1; funct3M = 3'b010; alu_resultM = 32'h100; req_ready = 1'b1; rsp_valid = 1'b0;
    tcyc = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c > 0 && lsu_err) begin tcyc = c; break; end
      @(negedge clk);
    end
    chk("timeout_cycle", tcyc, 8);
    chk("timeout_err_stall", {31'h0, stallM}, 32'h1);
    @(negedge clk);
    clear_inputs(); #1;
    chk("timeout_release", {29'h0, stallM, load_validM, req_valid}, 32'h0);
    chk("timeout_load_data", load_dataM, 32'h0);
`else
    tcyc = 0;
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
